// File: rtl/span_walker_pkg.sv
// Shared span field widths, FSM state type and colour packing for the span walker.
package span_walker_pkg;

  localparam int unsigned XW      = 10;
  localparam int unsigned ZW      = 26;
  localparam int unsigned RW      = 22;
  localparam int unsigned GW      = 22;
  localparam int unsigned BW      = 18;
  localparam int unsigned DEPTH_W = 16;
  // Stored/compared depth is the top DEPTH_W bits of Z, i.e. Z[25:10].
  localparam int unsigned ZLSB    = ZW - DEPTH_W;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StDrain
  } state_e;

  // RGB565 from the top bits of each channel accumulator.
  function automatic logic [15:0] pack_rgb565(input logic [RW-1:0] r, input logic [GW-1:0] g,
                                              input logic [BW-1:0] b);
    return {r[RW-1 -: 5], g[GW-1 -: 6], b[BW-1 -: 5]};
  endfunction

endpackage

// File: rtl/span_walker_if.sv
// Span interface from the line-setup stage plus the line-buffer depth read / pixel write port.
interface span_walker_if;
  import span_walker_pkg::*;

  logic              nextFrame;
  logic              lineStart;
  logic [XW-1:0]     X1;
  logic [XW-1:0]     X2;
  logic [ZW-1:0]     Z1;
  logic [ZW:0]       NZ;
  logic [RW-1:0]     R1;
  logic [RW:0]       NR;
  logic [GW-1:0]     G1;
  logic [GW:0]       NG;
  logic [BW-1:0]     B1;
  logic [BW:0]       NB;
  logic              lineDone;
  logic [XW-1:0]     zrd_addr;
  logic              zrd_en;
  logic [DEPTH_W-1:0] zrd_data;
  logic              pix_we;
  logic [XW-1:0]     pix_addr;
  logic [15:0]       pix_rgb;
  logic [DEPTH_W-1:0] pix_z;

  // Setup stage and line buffer side.
  modport master (
    output nextFrame, lineStart, X1, X2, Z1, NZ, R1, NR, G1, NG, B1, NB, zrd_data,
    input  lineDone, zrd_addr, zrd_en, pix_we, pix_addr, pix_rgb, pix_z
  );

  // Span walker side.
  modport slave (
    input  nextFrame, lineStart, X1, X2, Z1, NZ, R1, NR, G1, NG, B1, NB, zrd_data,
    output lineDone, zrd_addr, zrd_en, pix_we, pix_addr, pix_rgb, pix_z
  );

endinterface

// File: rtl/span_walker_sat_step.sv
// One saturating step of an unsigned accumulator by a signed delta one bit wider.
module span_walker_sat_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [W:0]   delta,
  output logic [W-1:0] result
);

  logic [W:0] sum;

  // Bit W of the (W+1)-bit sum flags overflow (positive delta) or underflow (negative delta).
  always_comb begin
    sum = {1'b0, acc} + delta;
    if (sum[W]) begin
      result = delta[W] ? '0 : '1;
    end else begin
      result = sum[W-1:0];
    end
  end

endmodule

// File: rtl/span_walker.sv
// Walks one span per lineStart at one pixel per cycle, depth-tests against the line buffer
// and writes colour/depth for visible pixels. Pipeline: S0 read, S1 compare, S2 write.
module span_walker
  import span_walker_pkg::*;
#(
  parameter int unsigned H_RES = 640
) (
  input logic          clk100,
  input logic          rst_n,
  span_walker_if.slave bus
);

  localparam logic [XW:0] HResX = H_RES[XW:0];

  state_e state_q, state_d;

  // S0 walk state and latched span parameters
  logic [XW-1:0] x_q, x2_q, x_next;
  logic          dir_dn_q;
  logic [ZW-1:0] z_q, z_next;
  logic [RW-1:0] r_q, r_next;
  logic [GW-1:0] g_q, g_next;
  logic [BW-1:0] b_q, b_next;
  logic [ZW:0]   nz_q;
  logic [RW:0]   nr_q;
  logic [GW:0]   ng_q;
  logic [BW:0]   nb_q;
  logic          start, issue, inrange0, line_done;

  // S1 compare stage
  logic               s1_valid_q, s1_inrange_q;
  logic [XW-1:0]      s1_x_q;
  logic [DEPTH_W-1:0] s1_z_q;
  logic [15:0]        s1_rgb_q;
  logic               pass;

  // S2 write stage
  logic               pix_we_q;
  logic [XW-1:0]      pix_addr_q;
  logic [15:0]        pix_rgb_q;
  logic [DEPTH_W-1:0] pix_z_q;

  assign x_next   = dir_dn_q ? x_q - 1'b1 : x_q + 1'b1;
  assign inrange0 = {1'b0, x_q} < HResX;
  assign pass     = s1_z_q < bus.zrd_data;

  span_walker_sat_step #(.W(ZW)) u_sat_z (.acc(z_q), .delta(nz_q), .result(z_next));
  span_walker_sat_step #(.W(RW)) u_sat_r (.acc(r_q), .delta(nr_q), .result(r_next));
  span_walker_sat_step #(.W(GW)) u_sat_g (.acc(g_q), .delta(ng_q), .result(g_next));
  span_walker_sat_step #(.W(BW)) u_sat_b (.acc(b_q), .delta(nb_q), .result(b_next));

  // FSM state register
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; nextFrame overrides everything, including lineStart
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    issue     = 1'b0;
    line_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        line_done = 1'b1;
        if (bus.lineStart) begin
          start   = 1'b1;
          state_d = (bus.X1 == bus.X2) ? StDrain : StWalk;
        end
      end
      StWalk: begin
        issue = 1'b1;
        if (x_next == x2_q) state_d = StDrain;
      end
      // S2 empties on the same edge that S1 is seen empty, so leave then.
      StDrain: begin
        if (!s1_valid_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bus.nextFrame) begin
      state_d = StIdle;
      start   = 1'b0;
      issue   = 1'b0;
    end
  end

  // S0: latch the span on start, then step x and the attributes once per issued pixel
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      x2_q     <= '0;
      dir_dn_q <= 1'b0;
      z_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      nz_q     <= '0;
      nr_q     <= '0;
      ng_q     <= '0;
      nb_q     <= '0;
    end else if (start) begin
      x_q      <= bus.X1;
      x2_q     <= bus.X2;
      dir_dn_q <= bus.X2 < bus.X1;
      z_q      <= bus.Z1;
      r_q      <= bus.R1;
      g_q      <= bus.G1;
      b_q      <= bus.B1;
      nz_q     <= bus.NZ;
      nr_q     <= bus.NR;
      ng_q     <= bus.NG;
      nb_q     <= bus.NB;
    end else if (issue) begin
      x_q <= x_next;
      z_q <= z_next;
      r_q <= r_next;
      g_q <= g_next;
      b_q <= b_next;
    end
  end

  // S1/S2: carry pixel data alongside the depth read, then register the write strobe
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_inrange_q <= 1'b0;
      s1_x_q       <= '0;
      s1_z_q       <= '0;
      s1_rgb_q     <= '0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_rgb_q    <= '0;
      pix_z_q      <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_inrange_q <= inrange0;
        s1_x_q       <= x_q;
        s1_z_q       <= z_q[ZW-1 -: DEPTH_W];
        s1_rgb_q     <= pack_rgb565(r_q, g_q, b_q);
      end
      pix_we_q <= !bus.nextFrame && s1_valid_q && s1_inrange_q && pass;
      if (s1_valid_q) begin
        pix_addr_q <= s1_x_q;
        pix_rgb_q  <= s1_rgb_q;
        pix_z_q    <= s1_z_q;
      end
    end
  end

  assign bus.lineDone = line_done;
  assign bus.zrd_en   = issue && inrange0;
  assign bus.zrd_addr = x_q;
  assign bus.pix_we   = pix_we_q;
  assign bus.pix_addr = pix_addr_q;
  assign bus.pix_rgb  = pix_rgb_q;
  assign bus.pix_z    = pix_z_q;

endmodule

// File: tb/tb_span_walker.sv
// Self-checking bench: a per-cycle expected-output schedule is built from the span rules
// (pixel k read at t+k, written at t+k+2, saturating attribute steps) and compared each cycle.
module tb_span_walker;

  localparam int MAXC = 12000;

  logic clk100 = 1'b0;
  logic rst_n  = 1'b0;

  span_walker_if bus ();

  span_walker #(.H_RES(640)) dut (
    .clk100(clk100),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk100 = ~clk100;

  // Line-buffer depth plane with one-cycle read latency.
  logic [15:0] mem [1024];
  always @(posedge clk100) if (bus.zrd_en) bus.zrd_data <= mem[bus.zrd_addr];

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int exp_done [MAXC];
  int exp_en   [MAXC];
  int exp_radr [MAXC];
  int exp_we   [MAXC];
  int exp_wadr [MAXC];
  int exp_rgb  [MAXC];
  int exp_z    [MAXC];
  int act_done [MAXC];
  int act_en   [MAXC];
  int act_we   [MAXC];
  int act_wadr [MAXC];
  int act_rgb  [MAXC];
  int act_z    [MAXC];

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;
  int busy_until = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint top = (longint'(1) << w) - 1;
    if (v < 0) return 0;
    if (v > top) return top;
    return v;
  endfunction

  // Fill the expected schedule for a span whose lineStart is sampled in cycle t.
  // f is the cycle nextFrame is high (or -1).
  task automatic model_span(input int t, input int x1, input int x2, input longint z1,
                            input longint nz, input longint r1, input longint nr,
                            input longint g1, input longint ng, input longint b1,
                            input longint nb, input int f);
    int n, dir, x, endc, rc;
    longint z, r, g, b;
    n    = (x2 > x1) ? x2 - x1 : x1 - x2;
    dir  = (x2 > x1) ? 1 : -1;
    endc = (n == 0) ? t + 2 : t + n + 3;
    if (f >= 0 && f + 1 < endc) endc = f + 1;
    for (int c = t + 1; c < endc && c < MAXC; c++) exp_done[c] = 0;
    x = x1; z = z1; r = r1; g = g1; b = b1;
    for (int k = 1; k <= n; k++) begin
      rc = t + k;
      if ((f < 0 || rc < f) && x < 640 && rc < MAXC) begin
        exp_en[rc]   = 1;
        exp_radr[rc] = x;
      end
      if ((f < 0 || f >= rc + 2) && x < 640 && (z >> 10) < longint'(mem[x]) &&
          rc + 2 < MAXC) begin
        exp_we[rc+2]   = 1;
        exp_wadr[rc+2] = x;
        exp_z[rc+2]    = int'(z >> 10);
        exp_rgb[rc+2]  = int'(((r >> 17) << 11) | ((g >> 16) << 5) | (b >> 13));
      end
      x = (x + dir) & 1023;
      z = sat(z + nz, 26);
      r = sat(r + nr, 22);
      g = sat(g + ng, 22);
      b = sat(b + nb, 18);
    end
    busy_until = endc;
    if (f >= 0 && f + 1 > busy_until) busy_until = f + 1;
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  // Issue one span once idle; foff > 0 pulses nextFrame at t+foff. Returns t.
  task automatic issue(input int x1, input int x2, input longint z1, input longint nz,
                       input longint r1, input longint nr, input longint g1, input longint ng,
                       input longint b1, input longint nb, input int foff, output int t);
    while (cyc < busy_until) step();
    t = cyc;
    bus.X1 = 10'(x1);  bus.X2 = 10'(x2);
    bus.Z1 = 26'(z1);  bus.NZ = 27'(nz);
    bus.R1 = 22'(r1);  bus.NR = 23'(nr);
    bus.G1 = 22'(g1);  bus.NG = 23'(ng);
    bus.B1 = 18'(b1);  bus.NB = 19'(nb);
    bus.lineStart = 1'b1;
    model_span(t, x1, x2, z1, nz, r1, nr, g1, ng, b1, nb, (foff > 0) ? t + foff : -1);
    step();
    bus.lineStart = 1'b0;
    if (foff > 0) begin
      while (cyc < t + foff) step();
      bus.nextFrame = 1'b1;
      step();
      bus.nextFrame = 1'b0;
    end
  endtask

  task automatic settle();
    while (cyc < busy_until + 1) step();
  endtask

  function automatic longint rnd_delta(input int mag);
    longint v = longint'($urandom_range(0, (1 << mag) - 1));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  // Per-cycle comparison against the schedule; also logs actuals for the literal checks.
  always @(negedge clk100) begin
    if (run && cyc < MAXC) begin
      act_done[cyc] = int'(bus.lineDone);
      act_en[cyc]   = int'(bus.zrd_en);
      act_we[cyc]   = int'(bus.pix_we);
      act_wadr[cyc] = int'(bus.pix_addr);
      act_rgb[cyc]  = int'(bus.pix_rgb);
      act_z[cyc]    = int'(bus.pix_z);
      chk($sformatf("lineDone c%0d", cyc), longint'(bus.lineDone), exp_done[cyc]);
      chk($sformatf("zrd_en c%0d", cyc), longint'(bus.zrd_en), exp_en[cyc]);
      if (exp_en[cyc] != 0)
        chk($sformatf("zrd_addr c%0d", cyc), longint'(bus.zrd_addr), exp_radr[cyc]);
      chk($sformatf("pix_we c%0d", cyc), longint'(bus.pix_we), exp_we[cyc]);
      if (exp_we[cyc] != 0) begin
        chk($sformatf("pix_addr c%0d", cyc), longint'(bus.pix_addr), exp_wadr[cyc]);
        chk($sformatf("pix_rgb c%0d", cyc), longint'(bus.pix_rgb), exp_rgb[cyc]);
        chk($sformatf("pix_z c%0d", cyc), longint'(bus.pix_z), exp_z[cyc]);
      end
    end
  end

  initial begin
    int t, x1, x2, d, foff;
    longint z1, nz, r1, nr, g1, ng, b1, nb;
    for (int c = 0; c < MAXC; c++) begin
      exp_done[c] = 1; exp_en[c] = 0; exp_we[c] = 0;
      exp_radr[c] = 0; exp_wadr[c] = 0; exp_rgb[c] = 0; exp_z[c] = 0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
    bus.nextFrame = 1'b0; bus.lineStart = 1'b0;
    bus.X1 = '0; bus.X2 = '0; bus.Z1 = '0; bus.NZ = '0;
    bus.R1 = '0; bus.NR = '0; bus.G1 = '0; bus.NG = '0; bus.B1 = '0; bus.NB = '0;

    // Reset values
    #3;
    chk("rst lineDone", longint'(bus.lineDone), 1);
    chk("rst zrd_en", longint'(bus.zrd_en), 0);
    chk("rst pix_we", longint'(bus.pix_we), 0);
    chk("rst zrd_addr", longint'(bus.zrd_addr), 0);
    chk("rst pix_addr", longint'(bus.pix_addr), 0);
    chk("rst pix_rgb", longint'(bus.pix_rgb), 0);
    chk("rst pix_z", longint'(bus.pix_z), 0);
    #14;
    rst_n = 1'b1;  // released mid-cycle
    run   = 1'b1;
    repeat (3) step();

    // Forward span 10..13, z 1..4
    issue(10, 14, 26'h400, 27'h400, 0, 0, 0, 0, 0, 0, 0, t);
    settle();
    chk("fwd done@t", act_done[t], 1);
    chk("fwd done@t+1", act_done[t+1], 0);
    chk("fwd we@t+3", act_we[t+3], 1);
    chk("fwd addr@t+3", act_wadr[t+3], 10);
    chk("fwd z@t+3", act_z[t+3], 1);
    chk("fwd addr@t+6", act_wadr[t+6], 13);
    chk("fwd z@t+6", act_z[t+6], 4);
    chk("fwd done@t+6", act_done[t+6], 0);
    chk("fwd done@t+7", act_done[t+7], 1);
    chk("fwd we@t+7", act_we[t+7], 0);

    // Reverse span 20, 19, 18
    issue(20, 17, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);
    settle();
    chk("rev addr@t+3", act_wadr[t+3], 20);
    chk("rev addr@t+4", act_wadr[t+4], 19);
    chk("rev addr@t+5", act_wadr[t+5], 18);

    // Empty span
    issue(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);
    settle();
    chk("empty done@t+1", act_done[t+1], 0);
    chk("empty done@t+2", act_done[t+2], 1);
    chk("empty we@t+3", act_we[t+3], 0);

    // Equal stored depth rejects
    mem[11] = 16'h0002;
    issue(10, 14, 26'h400, 27'h400, 0, 0, 0, 0, 0, 0, 0, t);
    settle();
    chk("ztie we@t+3", act_we[t+3], 1);
    chk("ztie we@t+4", act_we[t+4], 0);
    chk("ztie we@t+5", act_we[t+5], 1);
    mem[11] = 16'hFFFF;

    // Red saturates high, blue clamps low
    issue(100, 103, 0, 0, 22'h3FFFF0, 23'h20, 0, 0, 18'h10, -longint'(32), 0, t);
    settle();
    chk("sat rgb@t+4", act_rgb[t+4], 16'hF800);
    chk("sat rgb@t+5", act_rgb[t+5], 16'hF800);

    // Off the right edge: only 638, 639
    issue(638, 642, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);
    settle();
    chk("edge addr@t+3", act_wadr[t+3], 638);
    chk("edge addr@t+4", act_wadr[t+4], 639);
    chk("edge we@t+5", act_we[t+5], 0);
    chk("edge en@t+3", act_en[t+3], 0);

    // nextFrame at t+2 of a 10-pixel span
    issue(200, 210, 0, 0, 0, 0, 0, 0, 0, 0, 2, t);
    settle();
    chk("abort we@t+3", act_we[t+3], 0);
    chk("abort we@t+4", act_we[t+4], 0);
    chk("abort done@t+2", act_done[t+2], 0);
    chk("abort done@t+3", act_done[t+3], 1);

    // Randomized spans
    for (int s = 0; s < 150; s++) begin
      if (s % 10 == 0) begin
        settle();
        for (int i = 0; i < 1024; i++)
          mem[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      end
      x1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(600, 700))
                                        : int'($urandom_range(0, 1023));
      d  = int'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) x2 = (x1 + d > 1023) ? 1023 : x1 + d;
      else                           x2 = (x1 - d < 0) ? 0 : x1 - d;
      z1 = longint'($urandom & 32'h3FFFFFF);
      nz = rnd_delta(int'($urandom_range(4, 24)));
      r1 = longint'($urandom & 32'h3FFFFF);
      nr = rnd_delta(int'($urandom_range(4, 21)));
      g1 = longint'($urandom & 32'h3FFFFF);
      ng = rnd_delta(int'($urandom_range(4, 21)));
      b1 = longint'($urandom & 32'h3FFFF);
      nb = rnd_delta(int'($urandom_range(4, 17)));
      foff = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 25)) : 0;
      issue(x1, x2, z1, nz, r1, nr, g1, ng, b1, nb, foff, t);
    end
    settle();
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
